// File: rtl/xxhash32_feeder_if.sv
// Stream-in and digest-out valid/ready bundle between a message source/sink and xxhash32_feeder.
interface xxhash32_feeder_if #(
  parameter int WORD_SIZE = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic [WORD_SIZE-1:0] s_data;
  logic                 s_last;
  logic                 digest_valid;
  logic                 digest_ready;
  logic [WORD_SIZE-1:0] digest;

  modport master (
    output s_valid, s_data, s_last, digest_ready,
    input  s_ready, digest_valid, digest
  );
  modport slave (
    input  s_valid, s_data, s_last, digest_ready,
    output s_ready, digest_valid, digest
  );
endinterface

// File: rtl/xxhash32_feeder.sv
// Sequencer that seeds, feeds and queries one xxhash32 core and presents the digest.
// Optional XXHASH32_FEEDER_CHECK_EN adds an `expected` input and a registered `match` output.
module xxhash32_feeder #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] seed,
  xxhash32_feeder_if.slave     bus,
  output logic                 error,
  output logic                 busy,
  output logic [31:0]          word_count,
  output logic                 hash_seed_in,
  output logic                 hash_add_to_hash,
  output logic                 hash_request_hash,
  output logic [WORD_SIZE-1:0] hash_input_bytes,
  input  logic                 hash_ready,
  input  logic [WORD_SIZE-1:0] hash_output_hash
`ifdef XXHASH32_FEEDER_CHECK_EN
  ,
  input  logic [WORD_SIZE-1:0] expected,
  output logic                 match
`endif
);

  // state  | meaning
  // IDLE   | wait for start       SEED | seed strobe on pins     GAP0 | spacing before adds
  // STREAM | accept words         DRAIN| last add on pins        GAP1 | core block update
  // REQ    | request on pins      WAIT | await hash_ready        DONE | hold digest
  typedef enum logic [3:0] {
    IDLE, SEED, GAP0, STREAM, DRAIN, GAP1, REQ, WAIT, DONE
  } state_t;

  state_t               state, state_nxt;
  logic                 seed_in_nxt, add_nxt, req_nxt, err_nxt;
  logic [WORD_SIZE-1:0] data_nxt, digest_q, digest_nxt;
  logic [31:0]          wcnt_nxt;
  logic [7:0]           wait_cnt, wait_nxt;
`ifdef XXHASH32_FEEDER_CHECK_EN
  logic [WORD_SIZE-1:0] exp_q, exp_nxt;
  logic                 match_nxt;
`endif

  assign bus.s_ready      = (state == STREAM);
  assign bus.digest_valid = (state == DONE);
  assign bus.digest       = digest_q;
  assign busy             = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    seed_in_nxt = 1'b0;
    add_nxt     = 1'b0;
    req_nxt     = 1'b0;
    data_nxt    = hash_input_bytes;
    wcnt_nxt    = word_count;
    err_nxt     = error;
    digest_nxt  = digest_q;
    wait_nxt    = wait_cnt;
`ifdef XXHASH32_FEEDER_CHECK_EN
    exp_nxt     = exp_q;
    match_nxt   = match;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SEED;
          seed_in_nxt = 1'b1;
          data_nxt    = seed;
          wcnt_nxt    = 32'd0;
          err_nxt     = 1'b0;
`ifdef XXHASH32_FEEDER_CHECK_EN
          exp_nxt     = expected;
          match_nxt   = 1'b0;
`endif
        end
      end
      SEED: state_nxt = GAP0;
      GAP0: state_nxt = STREAM;
      STREAM: begin
        if (bus.s_valid) begin
          add_nxt  = 1'b1;
          data_nxt = bus.s_data;
          wcnt_nxt = word_count + 32'd1;
          if (bus.s_last) state_nxt = DRAIN;
        end
      end
      DRAIN: state_nxt = GAP1;
      GAP1: begin
        state_nxt = REQ;
        req_nxt   = 1'b1;
      end
      REQ: begin
        state_nxt = WAIT;
        wait_nxt  = 8'd0;
      end
      WAIT: begin
        // a result arriving on the timeout cycle still wins
        if (hash_ready) begin
          state_nxt  = DONE;
          digest_nxt = hash_output_hash;
`ifdef XXHASH32_FEEDER_CHECK_EN
          match_nxt  = (hash_output_hash == exp_q);
`endif
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt  = DONE;
          err_nxt    = 1'b1;
          digest_nxt = '0;
`ifdef XXHASH32_FEEDER_CHECK_EN
          match_nxt  = 1'b0;
`endif
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      DONE: if (bus.digest_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      hash_seed_in      <= 1'b0;
      hash_add_to_hash  <= 1'b0;
      hash_request_hash <= 1'b0;
      hash_input_bytes  <= '0;
      word_count        <= 32'd0;
      error             <= 1'b0;
      digest_q          <= '0;
      wait_cnt          <= 8'd0;
`ifdef XXHASH32_FEEDER_CHECK_EN
      exp_q             <= '0;
      match             <= 1'b0;
`endif
    end else begin
      state             <= state_nxt;
      hash_seed_in      <= seed_in_nxt;
      hash_add_to_hash  <= add_nxt;
      hash_request_hash <= req_nxt;
      hash_input_bytes  <= data_nxt;
      word_count        <= wcnt_nxt;
      error             <= err_nxt;
      digest_q          <= digest_nxt;
      wait_cnt          <= wait_nxt;
`ifdef XXHASH32_FEEDER_CHECK_EN
      exp_q             <= exp_nxt;
      match             <= match_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_xxhash32_feeder.sv
// Directed bench for xxhash32_feeder with a behavioural stub core and a reference hash model.
module tb_xxhash32_feeder;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [W-1:0]  seed;
  logic          error, busy;
  logic [31:0]   word_count;
  logic          hash_seed_in, hash_add_to_hash, hash_request_hash;
  logic [W-1:0]  hash_input_bytes;
  logic          hash_ready;
  logic [W-1:0]  hash_output_hash;
`ifdef XXHASH32_FEEDER_CHECK_EN
  logic [W-1:0]  expected;
  logic          match;
  logic [W-1:0]  cur_exp;
  bit            exp_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  xxhash32_feeder_if #(.WORD_SIZE(W)) sif ();

  xxhash32_feeder #(.WORD_SIZE(W), .TIMEOUT(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .seed              (seed),
    .bus               (sif),
    .error             (error),
    .busy              (busy),
    .word_count        (word_count),
    .hash_seed_in      (hash_seed_in),
    .hash_add_to_hash  (hash_add_to_hash),
    .hash_request_hash (hash_request_hash),
    .hash_input_bytes  (hash_input_bytes),
    .hash_ready        (hash_ready),
    .hash_output_hash  (hash_output_hash)
`ifdef XXHASH32_FEEDER_CHECK_EN
    ,
    .expected          (expected),
    .match             (match)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] r;
    r = {a[26:0], a[31:27]} ^ w;
    return r * 32'h9E3779B1 + 32'h85EBCA77;
  endfunction

  function automatic logic [31:0] fin(input logic [31:0] a);
    return (a ^ (a >> 13)) * 32'hC2B2AE3D;
  endfunction

  logic [31:0] msg[$];

  function automatic logic [31:0] model_hash(input logic [31:0] sd);
    logic [31:0] acc;
    acc = sd;
    foreach (msg[i]) acc = mix(acc, msg[i]);
    return fin(acc);
  endfunction

  // stub core: sticky ready cleared by seed, result one cycle after request
  int          cyc = 0;
  logic [31:0] core_acc = 32'd0;
  logic [31:0] core_out = 32'd0;
  logic        core_rdy = 1'b0;
  bit          mute = 1'b0;
  int          add_cnt = 0, add_run = 0, add_run_max = 0, overlap = 0, req_cyc = 0;

  assign hash_ready       = core_rdy;
  assign hash_output_hash = core_out;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    add_run <= hash_add_to_hash ? add_run + 1 : 0;
    if (hash_add_to_hash) begin
      core_acc <= mix(core_acc, hash_input_bytes);
      add_cnt  <= add_cnt + 1;
      if (add_run + 1 > add_run_max) add_run_max <= add_run + 1;
    end
    if (hash_request_hash) begin
      core_out <= fin(core_acc);
      core_rdy <= !mute;
      req_cyc  <= cyc;
      if (hash_add_to_hash) overlap <= overlap + 1;
    end
    if (hash_seed_in) begin
      core_acc    <= hash_input_bytes;
      core_rdy    <= 1'b0;
      add_cnt     <= 0;
      add_run_max <= 0;
    end
  end

  int el = 0;

  task automatic do_start(input logic [31:0] sd);
    @(negedge clk);
    start = 1'b1;
    seed  = sd;
`ifdef XXHASH32_FEEDER_CHECK_EN
    expected = cur_exp;
`endif
    @(negedge clk);
    start = 1'b0;
    chk_eq("seed_strobe", 32'(hash_seed_in), 32'd1);
    chk_eq("seed_data", hash_input_bytes, sd);
    chk_eq("busy_seed", 32'(busy), 32'd1);
    chk_eq("s_ready_seed", 32'(sif.s_ready), 32'd0);
    chk_eq("error_cleared", 32'(error), 32'd0);
    chk_eq("word_count_cleared", word_count, 32'd0);
    @(negedge clk);
    chk_eq("gap0_strobes", 32'({hash_seed_in, hash_add_to_hash, hash_request_hash}), 32'd0);
    chk_eq("s_ready_gap0", 32'(sif.s_ready), 32'd0);
    @(negedge clk);
    chk_eq("s_ready_stream", 32'(sif.s_ready), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int gap);
    sif.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    for (int t = 0; t < 50 && !sif.s_ready; t++) @(negedge clk);
    chk_eq("beat_ready", 32'(sif.s_ready), 32'd1);
    el = cyc;
    @(negedge clk);
  endtask

  task automatic finish_msg(input logic [31:0] exp_dig, input int exp_wc, input logic exp_err,
                            input int lat, input int hold, input bit poke);
    int          t;
    logic [31:0] held;
    bit          stable;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    t = 0;
    while (!sif.digest_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk_eq("digest_valid_seen", 32'(sif.digest_valid), 32'd1);
    chk_eq("digest_latency", 32'(cyc - 1 - el), 32'(lat));
    chk_eq("digest", sif.digest, exp_dig);
    chk_eq("word_count", word_count, 32'(exp_wc));
    chk_eq("error", 32'(error), 32'(exp_err));
`ifdef XXHASH32_FEEDER_CHECK_EN
    chk_eq("match", 32'(match), 32'(exp_dig == cur_exp && !exp_err));
`endif
    held   = sif.digest;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      start = poke && (i % 3 == 0);
      @(negedge clk);
      if (sif.digest !== held || !sif.digest_valid) stable = 1'b0;
    end
    start = 1'b0;
    chk_eq("digest_stable", 32'(stable), 32'd1);
    sif.digest_ready = 1'b1;
    start = poke;
    @(negedge clk);
    sif.digest_ready = 1'b0;
    start = 1'b0;
    chk_eq("digest_valid_drop", 32'(sif.digest_valid), 32'd0);
    chk_eq("idle_after_done", 32'(busy), 32'd0);
    chk_eq("no_reseed", 32'(hash_seed_in), 32'd0);
  endtask

  task automatic run_msg(input logic [31:0] sd, input bit gaps, input int hold,
                         input bit poke, input bit exp_err);
    logic [31:0] m;
    m = exp_err ? 32'd0 : model_hash(sd);
`ifdef XXHASH32_FEEDER_CHECK_EN
    cur_exp = model_hash(sd) ^ {31'd0, exp_flip};
`endif
    do_start(sd);
    foreach (msg[i]) send_word(msg[i], i == msg.size() - 1, gaps ? int'($urandom_range(0, 3)) : 0);
    finish_msg(m, msg.size(), exp_err, exp_err ? 19 : 4, hold, poke);
    chk_eq("request_edge", 32'(req_cyc - el), 32'd3);
    chk_eq("add_count", 32'(add_cnt), 32'(msg.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    seed  = '0;
`ifdef XXHASH32_FEEDER_CHECK_EN
    expected = '0;
    cur_exp  = '0;
`endif
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    sif.digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_s_ready", 32'(sif.s_ready), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_digest_valid", 32'(sif.digest_valid), 32'd0);
    chk_eq("rst_digest", sif.digest, 32'd0);
    chk_eq("rst_strobes", 32'({hash_seed_in, hash_add_to_hash, hash_request_hash, error}), 32'd0);
    chk_eq("rst_word_count", word_count, 32'd0);
    rst_n = 1'b1;

    // single word, last on first beat
    msg = '{32'h01234567};
    run_msg(32'h0, 1'b0, 0, 1'b0, 1'b0);

    // eight back-to-back words
    msg = '{32'h00000001, 32'hDEADBEEF, 32'hCAFEF00D, 32'h80000000,
            32'h7FFFFFFF, 32'h13579BDF, 32'h2468ACE0, 32'hFFFFFFFF};
    run_msg(32'h12345678, 1'b0, 0, 1'b0, 1'b0);
    chk_eq("back_to_back_adds", 32'(add_run_max), 32'd8);

    // five words with gaps, slow digest consumer, start pokes in DONE
    msg = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 32'h0F0F0F0F, 32'h11223344};
    run_msg(32'h9E3779B1, 1'b1, 10, 1'b1, 1'b0);

    // core never answers: timeout, then the next start clears error
    mute = 1'b1;
    msg = '{32'h0BADC0DE, 32'h00C0FFEE};
    run_msg(32'h0000BEEF, 1'b0, 2, 1'b0, 1'b1);
    mute = 1'b0;
    msg = '{32'h76543210};
    run_msg(32'h00000042, 1'b0, 0, 1'b0, 1'b0);

    // reset during STREAM after three words
    do_start(32'h55555555);
    send_word(32'h10000001, 1'b0, 0);
    send_word(32'h20000002, 1'b0, 0);
    send_word(32'h30000003, 1'b0, 0);
    sif.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_s_ready", 32'(sif.s_ready), 32'd0);
    chk_eq("arst_busy", 32'(busy), 32'd0);
    chk_eq("arst_strobes", 32'({hash_seed_in, hash_add_to_hash, hash_request_hash}), 32'd0);
    chk_eq("arst_data", hash_input_bytes, 32'd0);
    chk_eq("arst_word_count", word_count, 32'd0);
    chk_eq("arst_digest", sif.digest, 32'd0);
    chk_eq("arst_digest_valid", 32'(sif.digest_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    msg = '{32'hFACEB00C, 32'h0000FFFF, 32'hFFFF0000, 32'h12121212};
    run_msg(32'hAAAA5555, 1'b0, 0, 1'b0, 1'b0);

`ifdef XXHASH32_FEEDER_CHECK_EN
    msg = '{32'h31415926, 32'h27182818};
    exp_flip = 1'b0;
    run_msg(32'h00000007, 1'b0, 0, 1'b0, 1'b0);
    exp_flip = 1'b1;
    run_msg(32'h00000007, 1'b0, 0, 1'b0, 1'b0);
    exp_flip = 1'b0;
`endif

    chk_eq("add_request_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/xxhash32_feeder.md
# xxhash32_feeder

Initiator-side sequencer for the `xxhash32` core. It accepts a word stream with valid/ready framing and drives the core's seed/add/request strobes with the spacing the core requires. It captures the final hash and presents it on a valid/ready digest port. It sits between a message source (DMA or packet parser) and one `xxhash32` instance.

## Interface
Parameters:
- `WORD_SIZE`, 32: data word width; must match the core.
- `TIMEOUT`, 16: cycles to wait for `hash_ready` before flagging an error; range 2..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse in IDLE; begins a message; `seed` is sampled on the same cycle.
- `seed`  in  WORD_SIZE  hash seed.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  stream word accepted.
- `s_data`  in  WORD_SIZE  message word.
- `s_last`  in  1  final word of the message.
- `digest_valid`  out  1  digest available.
- `digest_ready`  in  1  digest consumed.
- `digest`  out  WORD_SIZE  captured hash.
- `error`  out  1  timeout sticky flag; cleared by the next `start`.
- `busy`  out  1  high in every state except IDLE.
- `word_count`  out  32  words accepted in the current or last message.
- `hash_seed_in`, `hash_add_to_hash`, `hash_request_hash`  out  1  core strobes, registered.
- `hash_input_bytes`  out  WORD_SIZE  core data, registered.
- `hash_ready`  in  1  core result flag.
- `hash_output_hash`  in  WORD_SIZE  core result.

## Operation
- States: IDLE, SEED, GAP0, STREAM, DRAIN, GAP1, REQ, WAIT, DONE.
- IDLE: `start`=1 latches `seed`, clears `word_count` and `error`, and moves to SEED. `start` in any other state is ignored.
- SEED: `hash_seed_in`=1 and `hash_input_bytes`=seed for exactly one cycle, then GAP0.
- GAP0: all strobes 0 for one cycle, then STREAM.
- STREAM: `s_ready`=1. Each beat with `s_valid&s_ready` registers `hash_add_to_hash`=1 and `hash_input_bytes`=`s_data` for the next cycle, and increments `word_count`. This gives back-to-back adds at one per cycle, which the core's ping-pong buffer sustains. A cycle without a beat drives `hash_add_to_hash`=0.
- A beat with `s_last` moves the FSM to DRAIN. In DRAIN the last add is on the core pins and `s_ready`=0.
- GAP1: one idle cycle so the core's block update completes before the request.
- REQ: `hash_request_hash`=1 for exactly one cycle. `hash_add_to_hash` is never high at the same time.
- WAIT: on `hash_ready`=1, capture `hash_output_hash` into `digest` and go to DONE.
  - A wait counter starts at 0 on entry to WAIT.
  - If the counter reaches `TIMEOUT` first: set `error`=1, `digest`=0, go to DONE.
- DONE: `digest_valid`=1 and `digest` is held stable until `digest_ready`=1, then IDLE. `start` in the same cycle as the handshake is ignored.
- Messages are at least one word long; `s_last` on the first beat is legal.
- `word_count` wraps modulo 2^32.
- Reset: all outputs are 0, `digest`=0, FSM is IDLE.
  - Reset asserted mid-message abandons the message.
  - The core is left unseeded; the next `start` reseeds it.

## Timing
- `start` sampled at edge E0: SEED during E0..E0+1, GAP0 next, `s_ready` high from edge E0+2.
- Last beat accepted at edge EL: the core samples the add at EL+1 and the request at EL+3. `hash_ready` is seen at EL+4, and `digest_valid` rises from edge EL+4.
- Minimum message cost: 7 cycles plus N words, with the digest taken immediately.
- `hash_ready` is sticky in the core. Its value is only trusted in WAIT, which always follows a seed that cleared it.

## Configuration
- `XXHASH32_FEEDER_CHECK_EN` defined: adds input `expected` [WORD_SIZE] and output `match`.
  - `expected` is latched with `seed` on `start`.
  - `match` is valid with `digest_valid` and equals `digest == expected_latched && !error`.
  - `match` resets to 0.
- Not defined: neither port exists and there is no compare logic.

## Test plan
- Single word, seed 0x0, data 0x01234567, `s_last` on the first beat -> exactly one add, request at EL+3, `digest_valid` at EL+4, `digest` equals the bench model, `word_count`=1.
- Eight back-to-back words, seed 0x12345678 -> eight consecutive `hash_add_to_hash` cycles, `digest` matches the model, `word_count`=8.
- Five words with random `s_valid` gaps and `digest_ready` held low 10 cycles -> add count 5, `digest` stable the whole time, `start` pulses in DONE ignored.
- Stub core whose `hash_ready` never rises, `TIMEOUT`=16 -> `error`=1 and `digest`=0 with `digest_valid` 16 cycles after entering WAIT. The next `start` clears `error`.
- `rst_n` low during STREAM after 3 words -> all outputs 0 asynchronously, FSM IDLE. A following 4-word message hashes correctly.
- CHECK_EN build: with `expected` = model value -> `match`=1; with `expected` = model^1 -> `match`=0.
